layer_control: RTL and testbench
================================

Name: layer_control

Overview:
- Sequences a layer of M associate units that share one input vector of N bytes.
- Forward pass: broadcasts each argument vector to all units, gathers the M 16-bit results, and presents them as one layer result word.
- Training pass (en latched): scatters the per-unit error, gathers each unit's N-lane feedback, sums it lane-wise with saturation, and emits one N-lane feedback word upstream.

Parameters:
- N, 2, inputs per unit (byte lanes of arg_dat; feedback lanes).
- M, 2, number of associate units controlled.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  training enable; sampled only on arg acceptance.
- arg_stb  in  1  upstream argument valid.
- arg_dat  in  8*N  argument vector.
- arg_rdy  out  1  ready for an argument.
- res_stb  out  1  layer result valid.
- res_dat  out  16*M  result of unit k in lane k.
- res_rdy  in  1  downstream accept.
- err_stb  in  1  error vector valid.
- err_dat  in  16*M  error for unit k in lane k.
- err_rdy  out  1  ready for an error.
- fbk_stb  out  1  summed feedback valid.
- fbk_dat  out  16*N  saturated lane-wise sum of unit feedback.
- fbk_rdy  in  1  upstream accept.
- u_en  out  1  latched en, driven to all units.
- u_arg_stb/u_arg_rdy  out/in  M  per-unit argument handshake.
- u_arg_dat  out  8*N  registered argument, common to all units.
- u_res_stb/u_res_rdy  in/out  M  per-unit result handshake.
- u_res_dat  in  16*M  unit results.
- u_err_stb/u_err_rdy  out/in  M  per-unit error handshake.
- u_err_dat  out  16*M  registered error lanes.
- u_fbk_stb/u_fbk_rdy  in/out  M  per-unit feedback handshake.
- u_fbk_dat  in  16*N*M  unit k occupies bits [16*N*k +: 16*N].

Behaviour:
- Handshake: a transfer occurs on a cycle where stb & rdy are both high. Strobes hold their data until acknowledged.
- Reset: state=ARG. All masks, counters and accumulators clear; u_en=0.
- Outputs after reset: arg_rdy=1; res_stb, err_rdy, fbk_stb = 0; every u_* strobe/ready = 0.
- A reset mid-transaction abandons it at once; no partial output appears afterwards.
- ARG state: arg_rdy=1.
  - On acceptance, latch arg_dat into u_arg_dat and en into u_en, set pend = all ones, go to BCST.
- BCST state: u_arg_stb = pend. A unit's pend bit clears on its ack.
  - Leave for GATH in the cycle after pend reaches zero. Units may accept in any order or cycle.
- GATH state: u_res_rdy = ~got.
  - On each unit ack, capture its lane into the res_dat register and set that got bit.
  - When got is all ones, go to RES.
- RES state: res_stb=1 until res_rdy.
  - On ack: go to DEL if u_en=1, else to ARG.
  - res_stb falls in the cycle after the ack.
- DEL state: err_rdy=1. On ack, register err_dat into u_err_dat, set pend = all ones, go to SCAT.
- SCAT state: u_err_stb = pend, with the same clearing rule as BCST. When pend is zero, clear accumulators, set cnt=0, go to COLL.
- COLL state: feedback is collected serially by unit index, cnt = 0..M-1.
  - u_fbk_rdy[cnt]=1 only; the other ready bits are 0.
  - On ack, every lane acc[i] <= sat16(acc[i] + u_fbk_dat lane i of unit cnt).
  - When cnt=M-1 and that unit acks, go to FBK.
  - Units with stb held while not selected are unaffected.
- Saturation: 17-bit signed sum, clamped to [-32768, 32767]. Feedback sum order is unit 0 first.
- FBK state: fbk_stb=1 with fbk_dat = acc until fbk_rdy, then go to ARG.
- arg_rdy, err_rdy, res_stb and fbk_stb are each high only in their own state. Input strobes arriving in other states are ignored, not buffered.
- Latency: a forward pass with all units ready and results valid completes ARG→RES in 4 cycles plus unit MAC time.
- M=1 degenerates correctly: pend and got are single bits, cnt is width 1.

Decomposition:
- Package layer_pkg holds:
  - state encodings ARG, BCST, GATH, RES, DEL, SCAT, COLL, FBK as a 3-bit typedef;
  - SAT_MAX=16'sh7fff, SAT_MIN=16'sh8000.
- Sub-module sat_add16: combinational 16+16 signed add with clamp, instantiated N times for the COLL accumulators.

Test Plan:
- N=2, M=2, en=0; args 0x10,0x20; units return results 0x0100 and 0xff00 in reversed order → res_dat=0xff000100, one res_stb pulse, then arg_rdy=1.
- Unit 1 delays u_arg_rdy 5 cycles → u_arg_stb[0] drops after its ack; u_arg_stb[1] stays high 5 cycles; BCST exits only after both acks.
- en=1; err lanes 0x0040 and 0xffc0 → each unit receives its own lane; fbk lanes {0x1000,0x0002} + {0x2000,0xfffe} → fbk_dat={0x0000,0x3000}.
- Feedback lane 0: 0x7000 + 0x7000 → 0x7fff; lane 1: 0x9000 + 0x9000 → 0x8000.
- en toggled high during GATH of an en=0 pass → RES returns to ARG and u_en stays 0.
- rst asserted during COLL after unit 0 ack → next cycle fbk_stb=0, all u_* ready/strobes 0, arg_rdy=1; the next pass produces a fresh result.

Source files
------------

// File: rtl/layer_pkg.sv
// layer_pkg: shared state encoding and saturation limits for the layer sequencer
package layer_pkg;
   typedef enum logic [2:0] {ARG, BCST, GATH, RES, DEL, SCAT, COLL, FBK} state_t;
   localparam logic signed [15:0] SAT_MAX = 16'sh7fff;
   localparam logic signed [15:0] SAT_MIN = 16'sh8000;
endpackage

// File: rtl/sat_add16.sv
// sat_add16: signed 16-bit add clamped to the 16-bit signed range
module sat_add16
   import layer_pkg::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] y
);
   logic [16:0] s;
   // overflow shows as the two top bits of the 17-bit sum disagreeing
   always_comb begin
      s = {a[15], a} + {b[15], b};
      y = (s[16] ^ s[15]) ? (s[16] ? SAT_MIN : SAT_MAX) : s[15:0];
   end
endmodule

// File: rtl/layer_control.sv
// layer_control: forward broadcast/gather and training scatter/collect for M units
module layer_control
   import layer_pkg::*;
#(
   parameter int N = 2,
   parameter int M = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              arg_stb,
   input  logic [8*N-1:0]    arg_dat,
   output logic              arg_rdy,
   output logic              res_stb,
   output logic [16*M-1:0]   res_dat,
   input  logic              res_rdy,
   input  logic              err_stb,
   input  logic [16*M-1:0]   err_dat,
   output logic              err_rdy,
   output logic              fbk_stb,
   output logic [16*N-1:0]   fbk_dat,
   input  logic              fbk_rdy,
   output logic              u_en,
   output logic [M-1:0]      u_arg_stb,
   input  logic [M-1:0]      u_arg_rdy,
   output logic [8*N-1:0]    u_arg_dat,
   input  logic [M-1:0]      u_res_stb,
   output logic [M-1:0]      u_res_rdy,
   input  logic [16*M-1:0]   u_res_dat,
   output logic [M-1:0]      u_err_stb,
   input  logic [M-1:0]      u_err_rdy,
   output logic [16*M-1:0]   u_err_dat,
   input  logic [M-1:0]      u_fbk_stb,
   output logic [M-1:0]      u_fbk_rdy,
   input  logic [16*N*M-1:0] u_fbk_dat
);
   localparam int CW = M > 1 ? $clog2(M) : 1;
   state_t state, nxt;
   logic [M-1:0] pend, got;
   logic [CW-1:0] cnt;
   logic [16*N-1:0] acc, sum, fsel;
   logic [16*M-1:0] res_q;

   assign res_dat = res_q;
   assign fbk_dat = acc;
   assign fsel = u_fbk_dat[16*N*cnt +: 16*N];

   for (genvar i = 0; i < N; i++) begin : g_sat
      sat_add16 u_sat (.a(acc[16*i +: 16]), .b(fsel[16*i +: 16]), .y(sum[16*i +: 16]));
   end

   // state register
   always_ff @(posedge clk)
      if (rst) state <= ARG;
      else state <= nxt;

   // next state and handshake outputs, each strobe/ready live only in its own state
   always_comb begin
      nxt = state;
      arg_rdy = 1'b0;
      res_stb = 1'b0;
      err_rdy = 1'b0;
      fbk_stb = 1'b0;
      u_arg_stb = '0;
      u_res_rdy = '0;
      u_err_stb = '0;
      u_fbk_rdy = '0;
      case (state)
         ARG: begin
            arg_rdy = 1'b1;
            if (arg_stb) nxt = BCST;
         end
         BCST: begin
            u_arg_stb = pend;
            if (pend == '0) nxt = GATH;
         end
         GATH: begin
            u_res_rdy = ~got;
            if (&got) nxt = RES;
         end
         RES: begin
            res_stb = 1'b1;
            if (res_rdy) nxt = u_en ? DEL : ARG;
         end
         DEL: begin
            err_rdy = 1'b1;
            if (err_stb) nxt = SCAT;
         end
         SCAT: begin
            u_err_stb = pend;
            if (pend == '0) nxt = COLL;
         end
         COLL: begin
            u_fbk_rdy = M'(1) << cnt;
            if (u_fbk_stb[cnt] && cnt == CW'(M - 1)) nxt = FBK;
         end
         FBK: begin
            fbk_stb = 1'b1;
            if (fbk_rdy) nxt = ARG;
         end
         default: nxt = ARG;
      endcase
   end

   // datapath: argument/error latches, pending masks, result capture, feedback accumulation
   always_ff @(posedge clk)
      if (rst) begin
         u_en <= 1'b0;
         u_arg_dat <= '0;
         u_err_dat <= '0;
         pend <= '0;
         got <= '0;
         cnt <= '0;
         acc <= '0;
         res_q <= '0;
      end else
         case (state)
            ARG: if (arg_stb) begin
               u_arg_dat <= arg_dat;
               u_en <= en;
               pend <= '1;
               got <= '0;
            end
            BCST: pend <= pend & ~u_arg_rdy;
            GATH: for (int k = 0; k < M; k++)
               if (u_res_stb[k] && !got[k]) begin
                  res_q[16*k +: 16] <= u_res_dat[16*k +: 16];
                  got[k] <= 1'b1;
               end
            DEL: if (err_stb) begin
               u_err_dat <= err_dat;
               pend <= '1;
            end
            SCAT: begin
               pend <= pend & ~u_err_rdy;
               if (pend == '0) begin
                  acc <= '0;
                  cnt <= '0;
               end
            end
            COLL: if (u_fbk_stb[cnt]) begin
               acc <= sum;
               cnt <= cnt + 1'b1;
            end
            default: ;
         endcase
endmodule

// File: tb/tb_layer_control.sv
// tb_layer_control: directed checks of forward, training, saturation and reset abandonment
module tb_layer_control;
   logic clk = 0, rst = 1, en = 0;
   logic arg_stb = 0, res_rdy = 0, err_stb = 0, fbk_rdy = 0;
   logic [15:0] arg_dat = 0;
   logic [31:0] err_dat = 0, u_res_dat = 0;
   logic [63:0] u_fbk_dat = 0;
   logic [1:0] u_arg_rdy = 0, u_res_stb = 0, u_err_rdy = 0, u_fbk_stb = 0;
   logic arg_rdy, res_stb, err_rdy, fbk_stb, u_en;
   logic [31:0] res_dat, fbk_dat, u_err_dat;
   logic [15:0] u_arg_dat;
   logic [1:0] u_arg_stb, u_res_rdy, u_err_stb, u_fbk_rdy;
   int checks = 0, errors = 0;

   layer_control #(.N(2), .M(2)) dut (
      .clk(clk), .rst(rst), .en(en),
      .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(arg_rdy),
      .res_stb(res_stb), .res_dat(res_dat), .res_rdy(res_rdy),
      .err_stb(err_stb), .err_dat(err_dat), .err_rdy(err_rdy),
      .fbk_stb(fbk_stb), .fbk_dat(fbk_dat), .fbk_rdy(fbk_rdy),
      .u_en(u_en),
      .u_arg_stb(u_arg_stb), .u_arg_rdy(u_arg_rdy), .u_arg_dat(u_arg_dat),
      .u_res_stb(u_res_stb), .u_res_rdy(u_res_rdy), .u_res_dat(u_res_dat),
      .u_err_stb(u_err_stb), .u_err_rdy(u_err_rdy), .u_err_dat(u_err_dat),
      .u_fbk_stb(u_fbk_stb), .u_fbk_rdy(u_fbk_rdy), .u_fbk_dat(u_fbk_dat)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_arg_rdy"}, arg_rdy, 1'b1);
      chk({tag, "_res_stb"}, res_stb, 1'b0);
      chk({tag, "_err_rdy"}, err_rdy, 1'b0);
      chk({tag, "_fbk_stb"}, fbk_stb, 1'b0);
      chk({tag, "_u_strb"}, {u_arg_stb, u_res_rdy, u_err_stb, u_fbk_rdy}, 8'h00);
   endtask

   task automatic fwd_pass(input logic [15:0] a, input logic e, input logic [31:0] r);
      arg_dat = a; en = e; arg_stb = 1; u_arg_rdy = 2'b11;
      tick();
      arg_stb = 0;
      chk("fp_u_arg_dat", u_arg_dat, a);
      chk("fp_u_en", u_en, e);
      tick();
      tick();
      chk("fp_gath_rdy", u_res_rdy, 2'b11);
      u_res_stb = 2'b11; u_res_dat = r;
      tick();
      u_res_stb = 0;
      tick();
      chk("fp_res_stb", res_stb, 1'b1);
      chk("fp_res_dat", res_dat, r);
      res_rdy = 1;
      tick();
      res_rdy = 0;
   endtask

   task automatic to_coll(input logic [31:0] e);
      chk("tc_err_rdy", err_rdy, 1'b1);
      u_err_rdy = 0; err_dat = e; err_stb = 1;
      tick();
      err_stb = 0;
      chk("tc_u_err_dat", u_err_dat, e);
      chk("tc_u_err_stb", u_err_stb, 2'b11);
      u_err_rdy = 2'b11;
      tick();
      tick();
      chk("tc_coll_rdy", u_fbk_rdy, 2'b01);
   endtask

   initial begin
      tick();
      tick();
      rst = 0;
      idle_chk("reset");
      chk("reset_u_en", u_en, 1'b0);
      err_stb = 1;
      tick();
      err_stb = 0;
      idle_chk("ignored_err");

      arg_dat = 16'h2010; en = 0; arg_stb = 1; u_arg_rdy = 2'b11;
      tick();
      arg_stb = 0;
      chk("p1_u_arg_dat", u_arg_dat, 16'h2010);
      chk("p1_bcst_stb", u_arg_stb, 2'b11);
      chk("p1_arg_rdy_low", arg_rdy, 1'b0);
      tick();
      chk("p1_pend_clr", u_arg_stb, 2'b00);
      tick();
      chk("p1_gath_rdy", u_res_rdy, 2'b11);
      u_res_stb = 2'b10; u_res_dat = 32'hff00_0000;
      tick();
      chk("p1_got1", u_res_rdy, 2'b01);
      u_res_stb = 2'b01; u_res_dat = 32'h0000_0100;
      tick();
      u_res_stb = 0;
      chk("p1_res_not_yet", res_stb, 1'b0);
      tick();
      chk("p1_res_stb", res_stb, 1'b1);
      chk("p1_res_dat", res_dat, 32'hff00_0100);
      tick();
      chk("p1_res_hold", res_stb, 1'b1);
      res_rdy = 1;
      tick();
      res_rdy = 0;
      idle_chk("p1_done");

      arg_dat = 16'h0304; arg_stb = 1; u_arg_rdy = 2'b01;
      tick();
      arg_stb = 0;
      chk("p2_bcst_stb", u_arg_stb, 2'b11);
      tick();
      u_arg_rdy = 2'b00;
      for (int i = 0; i < 4; i++) begin
         chk("p2_stb1_held", u_arg_stb, 2'b10);
         chk("p2_no_gath", u_res_rdy, 2'b00);
         tick();
      end
      chk("p2_stb1_fifth", u_arg_stb, 2'b10);
      u_arg_rdy = 2'b10;
      tick();
      chk("p2_pend_clr", u_arg_stb, 2'b00);
      chk("p2_still_bcst", u_res_rdy, 2'b00);
      tick();
      chk("p2_gath_rdy", u_res_rdy, 2'b11);
      en = 1;
      u_res_stb = 2'b11; u_res_dat = 32'h1234_5678;
      tick();
      u_res_stb = 0;
      tick();
      chk("p2_res_dat", res_dat, 32'h1234_5678);
      chk("p2_u_en_kept", u_en, 1'b0);
      res_rdy = 1;
      tick();
      res_rdy = 0;
      idle_chk("p2_back_arg");

      fwd_pass(16'h5566, 1'b1, 32'haaaa_bbbb);
      chk("p3_del_res_low", res_stb, 1'b0);
      to_coll(32'hffc0_0040);
      u_fbk_stb = 2'b11; u_fbk_dat = 64'hfffe2000_00021000;
      tick();
      chk("p3_coll_u1", u_fbk_rdy, 2'b10);
      tick();
      u_fbk_stb = 0;
      chk("p3_fbk_stb", fbk_stb, 1'b1);
      chk("p3_fbk_dat", fbk_dat, 32'h0000_3000);
      chk("p3_fbk_u_rdy", u_fbk_rdy, 2'b00);
      tick();
      chk("p3_fbk_hold", fbk_stb, 1'b1);
      fbk_rdy = 1;
      tick();
      fbk_rdy = 0;
      idle_chk("p3_done");

      fwd_pass(16'h0101, 1'b1, 32'h0001_0002);
      to_coll(32'h0003_0004);
      u_fbk_stb = 2'b11; u_fbk_dat = 64'h90007000_90007000;
      tick();
      tick();
      u_fbk_stb = 0;
      chk("p4_sat_dat", fbk_dat, 32'h8000_7fff);
      fbk_rdy = 1;
      tick();
      fbk_rdy = 0;
      idle_chk("p4_done");

      fwd_pass(16'h0202, 1'b1, 32'h0005_0006);
      to_coll(32'h0007_0008);
      u_fbk_stb = 2'b01; u_fbk_dat = 64'h0000_0000_1111_2222;
      tick();
      u_fbk_stb = 0;
      chk("p5_unit0_acked", u_fbk_rdy, 2'b10);
      rst = 1;
      tick();
      idle_chk("p5_rst");
      chk("p5_rst_u_en", u_en, 1'b0);
      rst = 0;
      tick();
      idle_chk("p5_after");
      fwd_pass(16'h0909, 1'b0, 32'hbeef_cafe);
      idle_chk("p5_fresh");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
